q2a03_oam_dma: RTL and testbench

- Sprite DMA engine for the $4014 register, placed between the Q2A03 core's bus outputs and the system bus.
- Snoops CPU writes to $4014 and halts the core through its ready input.
- Performs 256 read/write pairs that copy page {V,00..FF} to $2004, then releases the core.
- Muxes the system bus: CPU owns it when the engine is idle; the engine owns it during transfer.

---
 rtl/q2a03_oam_dma.sv | 127 ++++++++++++
 tb/tb_q2a03_oam_dma.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/q2a03_oam_dma.sv
`default_nettype none
// ============================================================================
// Module   : q2a03_oam_dma
// Purpose  : $4014 sprite DMA engine between the Q2A03 core and the system bus.
//            It stalls the core, copies one 256-byte page to $2004, then
//            hands the bus back to the core.
// Revision : 1.0  initial release
// ============================================================================
module q2a03_oam_dma #(
    parameter logic [15:0] DMA_REG  = 16'h4014,
    parameter logic [15:0] OAM_DATA = 16'h2004,
    parameter int          XFER_LEN = 256
) (
    input  logic        G_clock,
    input  logic        G_reset,
    input  logic        cyc_stb,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wr_data,
    input  logic        cpu_rdwr,
    input  logic        ext_ready,
    input  logic [7:0]  bus_rd_data,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wr_data,
    output logic        bus_rdwr,
    output logic        cpu_ready,
    output logic        dma_active
);

    localparam logic [7:0] c_LAST_IDX = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t     r_state;
    logic [7:0] r_page;
    logic [7:0] r_idx;
    logic       r_odd;
    logic [7:0] r_data_q;
    logic       r_dma_active;

    logic       w_trigger;

    assign w_trigger = (cpu_addr == DMA_REG) && !cpu_rdwr;

    always_ff @(posedge G_clock or negedge G_reset) begin
        if (!G_reset) begin
            r_state      <= S_IDLE;
            r_page       <= 8'h00;
            r_idx        <= 8'h00;
            r_odd        <= 1'b0;
            r_data_q     <= 8'h00;
            r_dma_active <= 1'b0;
        end else if (cyc_stb) begin
            r_odd <= ~r_odd;
            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_page       <= cpu_wr_data;
                        r_idx        <= 8'h00;
                        r_state      <= S_HALT;
                        r_dma_active <= 1'b1;
                    end
                end
                S_HALT: begin
                    // The core only honours RDY on reads, so writes keep us here.
                    // Parity after this strobe's toggle is ~r_odd.
                    if (cpu_rdwr) begin
                        r_state <= (~r_odd) ? S_ALIGN : S_READ;
                    end
                end
                S_ALIGN: begin
                    r_state <= S_READ;
                end
                S_READ: begin
                    r_data_q <= bus_rd_data;
                    r_state  <= S_WRITE;
                end
                S_WRITE: begin
                    if (r_idx == c_LAST_IDX) begin
                        r_state      <= S_IDLE;
                        r_dma_active <= 1'b0;
                    end else begin
                        r_idx   <= r_idx + 8'd1;
                        r_state <= S_READ;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_dma_active <= 1'b0;
                end
            endcase
        end
    end

    // Bus mux: only READ/WRITE take the bus; HALT/ALIGN still forward the stalled CPU read.
    always_comb begin
        bus_addr    = cpu_addr;
        bus_wr_data = cpu_wr_data;
        bus_rdwr    = cpu_rdwr;
        case (r_state)
            S_READ: begin
                bus_addr = {r_page, r_idx};
                bus_rdwr = 1'b1;
            end
            S_WRITE: begin
                bus_addr    = OAM_DATA;
                bus_wr_data = r_data_q;
                bus_rdwr    = 1'b0;
            end
            default: begin
                bus_addr    = cpu_addr;
                bus_wr_data = cpu_wr_data;
                bus_rdwr    = cpu_rdwr;
            end
        endcase
    end

    assign cpu_ready  = (r_state == S_IDLE) && ext_ready;
    assign dma_active = r_dma_active;

endmodule
`default_nettype wire

// File: tb/tb_q2a03_oam_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_q2a03_oam_dma
// Purpose  : Randomized bench for q2a03_oam_dma against a transaction-level
//            model of the expected per-CPU-cycle bus activity.
// Revision : 1.0  initial release
// ============================================================================
module tb_q2a03_oam_dma;

    logic        G_clock;
    logic        G_reset;
    logic        cyc_stb;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wr_data;
    logic        cpu_rdwr;
    logic        ext_ready;
    wire  [7:0]  bus_rd_data;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wr_data;
    logic        bus_rdwr;
    logic        cpu_ready;
    logic        dma_active;

    logic [7:0]  mem [65536];
    int          n_cmp;
    int          n_err;
    int          n_stb;
    int          stall;

    q2a03_oam_dma u_dut (
        .G_clock     (G_clock),
        .G_reset     (G_reset),
        .cyc_stb     (cyc_stb),
        .cpu_addr    (cpu_addr),
        .cpu_wr_data (cpu_wr_data),
        .cpu_rdwr    (cpu_rdwr),
        .ext_ready   (ext_ready),
        .bus_rd_data (bus_rd_data),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_rdwr    (bus_rdwr),
        .cpu_ready   (cpu_ready),
        .dma_active  (dma_active)
    );

    assign bus_rd_data = mem[bus_addr];

    initial G_clock = 1'b0;
    always #5 G_clock = ~G_clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cpu cycle %0d)", tag, obs, exp, n_stb);
        end
    endtask

    // One CPU cycle: drive the core side, check the bus as the model expects, then strobe.
    task automatic stb(input logic [15:0] ca, input logic [7:0] cd, input logic crw,
                       input logic [15:0] ea, input logic erw, input logic [7:0] ed,
                       input logic idle, input logic rnd_ext, input string tag);
        cpu_addr    = ca;
        cpu_wr_data = cd;
        cpu_rdwr    = crw;
        ext_ready   = rnd_ext ? 1'($urandom) : 1'b1;
        repeat ($urandom_range(0, 2)) @(negedge G_clock);
        @(negedge G_clock);
        check_val({tag, ".addr"}, 32'(bus_addr), 32'(ea));
        check_val({tag, ".rdwr"}, 32'(bus_rdwr), 32'(erw));
        if (!erw) check_val({tag, ".wdata"}, 32'(bus_wr_data), 32'(ed));
        check_val({tag, ".ready"}, 32'(cpu_ready), idle ? 32'(ext_ready) : 32'd0);
        check_val({tag, ".active"}, 32'(dma_active), 32'(!idle));
        if (!cpu_ready) stall++;
        cyc_stb = 1'b1;
        @(negedge G_clock);
        cyc_stb = 1'b0;
        n_stb++;
    endtask

    task automatic idle_stb();
        logic [15:0] a;
        a = 16'h0300 | 16'($urandom_range(0, 255));
        stb(a, 8'h00, 1'b1, a, 1'b1, 8'h00, 1'b1, 1'b0, "idle");
    endtask

    task automatic parity_to(input int p);
        if ((n_stb % 2) != p) idle_stb();
    endtask

    task automatic pass_through_now(input string tag);
        check_val({tag, ".active"}, 32'(dma_active), 32'd0);
        check_val({tag, ".ready"}, 32'(cpu_ready), 32'(ext_ready));
        check_val({tag, ".addr"}, 32'(bus_addr), 32'(cpu_addr));
        check_val({tag, ".rdwr"}, 32'(bus_rdwr), 32'(cpu_rdwr));
        check_val({tag, ".wdata"}, 32'(bus_wr_data), 32'(cpu_wr_data));
    endtask

    // Expected cycle sequence: trigger, w pushes, stalled read (twice if it lands
    // on an odd cycle), 256 read/write pairs, then the core owns the bus again.
    task automatic run_xfer(input logic [7:0] pg, input int w, input bit trig_in_halt,
                            input int abort_idx);
        bit          align;
        logic [15:0] ra;
        logic [15:0] pa;
        logic [7:0]  d;
        align = ((n_stb + w) % 2) == 1;
        stall = 0;
        stb(16'h4014, pg, 1'b0, 16'h4014, 1'b0, pg, 1'b1, 1'b0, "trig");
        for (int k = 0; k < w; k++) begin
            pa = (trig_in_halt && k == 1) ? 16'h4014 : 16'h01FD - 16'(k);
            d  = (trig_in_halt && k == 1) ? ~pg : 8'($urandom);
            stb(pa, d, 1'b0, pa, 1'b0, d, 1'b0, 1'b1, "push");
        end
        ra = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
        stb(ra, 8'($urandom), 1'b1, ra, 1'b1, 8'h00, 1'b0, 1'b1, "hread");
        if (align) stb(ra, 8'($urandom), 1'b1, ra, 1'b1, 8'h00, 1'b0, 1'b1, "align");
        for (int i = 0; i < 256; i++) begin
            pa = {pg, 8'(i)};
            if (i == abort_idx) begin
                cpu_addr    = 16'($urandom);
                cpu_wr_data = 8'($urandom);
                cpu_rdwr    = 1'($urandom);
                ext_ready   = 1'($urandom);
                @(negedge G_clock);
                #2 G_reset = 1'b0;
                #1 pass_through_now("abort");
                @(negedge G_clock);
                pass_through_now("abort_hold");
                G_reset = 1'b1;
                n_stb   = 0;
                return;
            end
            stb(16'($urandom), 8'($urandom), 1'($urandom), pa, 1'b1, 8'h00, 1'b0, 1'b1, "rd");
            stb(16'($urandom), 8'($urandom), 1'($urandom), 16'h2004, 1'b0, mem[pa],
                1'b0, 1'b1, "wr");
        end
        check_val("stall", 32'(stall), 32'(1 + w + (align ? 1 : 0) + 512));
        d = 8'($urandom);
        stb(16'h0300, d, 1'b0, 16'h0300, 1'b0, d, 1'b1, 1'b0, "post");
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        n_stb       = 0;
        stall       = 0;
        G_reset     = 1'b0;
        cyc_stb     = 1'b0;
        cpu_addr    = 16'h4014;
        cpu_wr_data = 8'h02;
        cpu_rdwr    = 1'b0;
        ext_ready   = 1'b1;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

        repeat (3) @(negedge G_clock);
        pass_through_now("reset");
        G_reset = 1'b1;
        @(negedge G_clock);

        // Non-triggering accesses near the DMA register
        stb(16'h4013, 8'h11, 1'b0, 16'h4013, 1'b0, 8'h11, 1'b1, 1'b1, "nt4013");
        stb(16'h4015, 8'h22, 1'b0, 16'h4015, 1'b0, 8'h22, 1'b1, 1'b1, "nt4015");
        stb(16'h4014, 8'h33, 1'b1, 16'h4014, 1'b1, 8'h33, 1'b1, 1'b1, "ntrd");
        idle_stb();

        parity_to(0);
        run_xfer(8'h02, 0, 1'b0, -1);
        parity_to(1);
        run_xfer(8'h02, 0, 1'b0, -1);
        run_xfer(8'h37, 2, 1'b1, -1);
        run_xfer(8'hFF, 0, 1'b0, -1);
        run_xfer(8'hFF, 3, 1'b0, -1);

        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 3)) idle_stb();
            run_xfer(8'($urandom), int'($urandom_range(0, 3)), 1'b0, -1);
        end

        parity_to(0);
        run_xfer(8'h02, 0, 1'b0, 8'h40);
        for (int k = 0; k < 4; k++) begin
            stb(16'h2004, 8'h00, 1'b1, 16'h2004, 1'b1, 8'h00, 1'b1, 1'b1, "postrst");
        end
        run_xfer(8'($urandom), 1, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish (got running, expected done)");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
